// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard with a private tag pipe of in-flight writers.
// Build with HAZARD_FORWARD_EN for forwarding mode; default is stall-only.
module hazard_scoreboard #(
  parameter int NUM_REGS   = 16,
  parameter int REG_W      = 4,
  parameter int PIPE_DEPTH = 2,
  parameter int SEL_W      = $clog2(PIPE_DEPTH + 1),
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                flush,
  input  logic                issue_wb_en,
  input  logic                issue_mem_r_en,
  input  logic [REG_W-1:0]    issue_dest,
  input  logic [REG_W-1:0]    src1,
  input  logic [REG_W-1:0]    src2,
  input  logic                two_src,
  output logic                hazard,
  output logic [SEL_W-1:0]    fwd_sel1,
  output logic [SEL_W-1:0]    fwd_sel2,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] dest;
    logic             ld;
  } tag_t;

  tag_t pipe_q [PIPE_DEPTH];

  logic [PIPE_DEPTH-1:0] m1;
  logic [PIPE_DEPTH-1:0] m2;

  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      m1[k] = pipe_q[k].vld &&
              (pipe_q[k].dest == src1);
      m2[k] = pipe_q[k].vld && two_src &&
              (pipe_q[k].dest == src2);
    end
  end

`ifdef HAZARD_FORWARD_EN
  // Scan oldest to youngest so the youngest match is written last.
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      if (m1[k]) fwd_sel1 = SEL_W'(k + 1);
      if (m2[k]) fwd_sel2 = SEL_W'(k + 1);
    end
    hazard = (m1[0] | m2[0]) & pipe_q[0].ld;
  end
`else
  logic unused_ld;

  always_comb begin
    unused_ld = 1'b0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      unused_ld = unused_ld ^ pipe_q[k].ld;
    end
  end

  assign fwd_sel1 = '0;
  assign fwd_sel2 = '0;
  assign hazard   = (|m1) | (|m2);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        pipe_q[k] <= '0;
      end
    end else if (!freeze) begin
      pipe_q[0] <= '{
        vld:  issue_wb_en & ~hazard & ~flush,
        dest: issue_dest,
        ld:   issue_mem_r_en
      };
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  // Dests outside the tracked register range never set a bit.
  always_comb begin
    pending_mask = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (pipe_q[k].vld &&
            pipe_q[k].dest == REG_W'(r)) begin
          pending_mask[r] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (hazard && !freeze &&
                 stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
